lfsr_stream_cipher: RTL and testbench

LFSR_STREAM_CIPHER -- requirements
Module: lfsr_stream_cipher

---
 rtl/lfsr_stream_cipher.sv | 80 ++++++++
 tb/tb_lfsr_stream_cipher.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_stream_cipher.sv
// Stream cipher: XORs each accepted word with the low bits of a 16-bit Fibonacci LFSR.
// Encrypt and decrypt are the same operation given the same key and word order.
module lfsr_stream_cipher #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_load,
  input  logic [15:0]      key,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             keyed,
  output logic [CNT_W-1:0] word_cnt
);

  localparam int unsigned LFSR_W = 16;
  localparam logic [LFSR_W-1:0] ZERO_KEY_SEED = 16'hACE1;

  typedef enum logic {
    ST_UNKEYED = 1'b0,
    ST_KEYED   = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
  logic               lfsr_fb;
  logic               accept;
  logic               out_valid_d;
  logic [WIDTH-1:0]   out_data_d;
  logic [CNT_W-1:0]   word_cnt_d;

  assign keyed    = (state_q == ST_KEYED);
  assign in_ready = keyed && !key_load && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign lfsr_fb  = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  // Next-state: key_load has priority over accept and over output drain.
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    out_valid_d = out_valid;
    out_data_d  = out_data;
    word_cnt_d  = word_cnt;
    if (key_load) begin
      state_d     = ST_KEYED;
      lfsr_d      = (key == '0) ? ZERO_KEY_SEED : key;
      word_cnt_d  = '0;
      out_valid_d = 1'b0;
    end else if (accept) begin
      lfsr_d      = {lfsr_q[14:0], lfsr_fb};
      out_data_d  = in_data ^ lfsr_q[WIDTH-1:0];
      out_valid_d = 1'b1;
      word_cnt_d  = word_cnt + CNT_W'(1);
    end else if (out_valid && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_UNKEYED;
      lfsr_q    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      word_cnt  <= '0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      word_cnt  <= word_cnt_d;
    end
  end

endmodule

// File: tb/tb_lfsr_stream_cipher.sv
// Scoreboard bench: an encrypting instance chained into a decrypting one, with
// a reference keystream model predicting every output word.
module tb_lfsr_stream_cipher;

  logic        clk;
  logic        rst_n;
  logic        key_load;
  logic        dec_key_load;
  logic [15:0] key;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        tb_out_ready;
  logic        dec_out_ready;
  logic        chain;

  logic        enc_in_ready, enc_out_valid, enc_out_ready, enc_keyed;
  logic [7:0]  enc_out_data;
  logic [15:0] enc_word_cnt;
  logic        dec_in_valid, dec_in_ready, dec_out_valid, dec_keyed;
  logic [7:0]  dec_out_data;
  logic [15:0] dec_word_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int rt_cnt = 0;
  logic [7:0]  sb_q[$];
  logic [7:0]  rt_q[$];
  logic [15:0] model_s;
  logic [7:0]  ks_exp [3];

  assign enc_out_ready = chain ? dec_in_ready : tb_out_ready;
  assign dec_in_valid  = chain && enc_out_valid;

  lfsr_stream_cipher #(.WIDTH(8), .CNT_W(16)) u_enc (
    .clk(clk), .rst_n(rst_n), .key_load(key_load), .key(key),
    .in_valid(in_valid), .in_ready(enc_in_ready), .in_data(in_data),
    .out_valid(enc_out_valid), .out_ready(enc_out_ready), .out_data(enc_out_data),
    .keyed(enc_keyed), .word_cnt(enc_word_cnt)
  );

  lfsr_stream_cipher #(.WIDTH(8), .CNT_W(16)) u_dec (
    .clk(clk), .rst_n(rst_n), .key_load(dec_key_load), .key(key),
    .in_valid(dec_in_valid), .in_ready(dec_in_ready), .in_data(enc_out_data),
    .out_valid(dec_out_valid), .out_ready(dec_out_ready), .out_data(dec_out_data),
    .keyed(dec_keyed), .word_cnt(dec_word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // Scoreboard: pop on output handshakes, push on input accepts.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      rt_q.delete();
    end else begin
      if (enc_out_valid && enc_out_ready) begin
        if (sb_q.size() == 0) check("sb_enc_underflow", 32'd0, 32'd1);
        else check("sb_enc", 32'(enc_out_data), 32'(sb_q.pop_front()));
      end
      if (dec_out_valid && dec_out_ready) begin
        rt_cnt++;
        if (rt_q.size() == 0) check("sb_dec_underflow", 32'd0, 32'd1);
        else check("sb_dec", 32'(dec_out_data), 32'(rt_q.pop_front()));
      end
      if (dec_key_load) rt_q.delete();
      if (key_load) begin
        sb_q.delete();
        model_s = (key == 16'h0000) ? 16'hACE1 : key;
      end else if (in_valid && enc_in_ready) begin
        sb_q.push_back(in_data ^ model_s[7:0]);
        if (chain) rt_q.push_back(in_data);
        model_s = lfsr_step(model_s);
      end
    end
  end

  task automatic load_key(input logic [15:0] k, input logic both);
    key          = k;
    key_load     = 1'b1;
    dec_key_load = both;
    @(posedge clk); #1;
    key_load     = 1'b0;
    dec_key_load = 1'b0;
  endtask

  // Holds in_valid with d until accepted; returns 1 time unit after the accept edge.
  task automatic send(input logic [7:0] d);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!enc_in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check("send_timeout", 32'(guard), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    ks_exp = '{8'h01, 8'h02, 8'h04};
    model_s = 16'h0000;
    rst_n = 1'b0; key_load = 1'b0; dec_key_load = 1'b0; key = 16'h0000;
    in_valid = 1'b1; in_data = 8'hFF; tb_out_ready = 1'b1; dec_out_ready = 1'b1;
    chain = 1'b0;

    // Reset state with in_valid held high
    #12;
    check("rst_in_ready", 32'(enc_in_ready), 32'd0);
    check("rst_out_valid", 32'(enc_out_valid), 32'd0);
    check("rst_out_data", 32'(enc_out_data), 32'd0);
    check("rst_keyed", 32'(enc_keyed), 32'd0);
    check("rst_word_cnt", 32'(enc_word_cnt), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("unkeyed_in_ready", 32'(enc_in_ready), 32'd0);
    check("unkeyed_keyed", 32'(enc_keyed), 32'd0);
    check("unkeyed_out_valid", 32'(enc_out_valid), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;

    // Keystream from key 0x0001, back-to-back accepts
    load_key(16'h0001, 1'b0);
    check("ks_keyed", 32'(enc_keyed), 32'd1);
    in_valid = 1'b1;
    in_data  = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ks_in_ready", 32'(enc_in_ready), 32'd1);
      @(posedge clk); #1;
      check("ks_out_valid", 32'(enc_out_valid), 32'd1);
      check("ks_out_data", 32'(enc_out_data), 32'(ks_exp[i]));
    end
    in_valid = 1'b0;
    check("ks_word_cnt", 32'(enc_word_cnt), 32'd3);
    @(posedge clk); #1;
    check("ks_drain_valid", 32'(enc_out_valid), 32'd0);

    // Zero key substitutes 0xACE1
    load_key(16'h0000, 1'b0);
    send(8'h00);
    in_valid = 1'b0;
    check("zk_out_data", 32'(enc_out_data), 32'hE1);

    // Backpressure for 5 cycles
    @(posedge clk); #1;
    load_key(16'h5A5A, 1'b0);
    tb_out_ready = 1'b0;
    send(8'h11);
    in_data = 8'h22;
    repeat (5) begin
      @(negedge clk);
      check("bp_out_data", 32'(enc_out_data), 32'h4B);
      check("bp_in_ready", 32'(enc_in_ready), 32'd0);
      check("bp_out_valid", 32'(enc_out_valid), 32'd1);
    end
    @(posedge clk); #1;
    tb_out_ready = 1'b1;
    send(8'h22);
    send(8'h33);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("bp_drained", 32'(sb_q.size()), 32'd0);
    check("bp_word_cnt", 32'(enc_word_cnt), 32'd3);

    // Rekey mid-stream with in_valid high
    load_key(16'h1234, 1'b0);
    send(8'hA0);
    send(8'hA1);
    in_data  = 8'hA2;
    key      = 16'h0001;
    key_load = 1'b1;
    @(negedge clk);
    check("rk_in_ready", 32'(enc_in_ready), 32'd0);
    @(posedge clk); #1;
    key_load = 1'b0;
    in_valid = 1'b0;
    check("rk_out_valid", 32'(enc_out_valid), 32'd0);
    check("rk_word_cnt", 32'(enc_word_cnt), 32'd0);
    send(8'h00);
    in_valid = 1'b0;
    check("rk_restart_data", 32'(enc_out_data), 32'h01);
    check("rk_restart_cnt", 32'(enc_word_cnt), 32'd1);

    // Round trip through the decrypting instance
    @(posedge clk); #1;
    chain = 1'b1;
    load_key(16'hBEEF, 1'b1);
    rt_cnt = 0;
    for (int v = 1; v <= 16; v++) send(8'(v));
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rt_count", 32'(rt_cnt), 32'd16);
    check("rt_dec_drained", 32'(rt_q.size()), 32'd0);
    check("rt_enc_drained", 32'(sb_q.size()), 32'd0);
    check("rt_dec_word_cnt", 32'(dec_word_cnt), 32'd16);

    // Reset asserted mid-stream with words pending in both instances
    load_key(16'hBEEF, 1'b1);
    dec_out_ready = 1'b0;
    send(8'h01);
    send(8'h02);
    in_data = 8'h03;
    check("mr_pre_enc_valid", 32'(enc_out_valid), 32'd1);
    check("mr_pre_dec_valid", 32'(dec_out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_enc_valid", 32'(enc_out_valid), 32'd0);
    check("mr_dec_valid", 32'(dec_out_valid), 32'd0);
    check("mr_enc_data", 32'(enc_out_data), 32'd0);
    check("mr_dec_data", 32'(dec_out_data), 32'd0);
    check("mr_enc_keyed", 32'(enc_keyed), 32'd0);
    check("mr_dec_keyed", 32'(dec_keyed), 32'd0);
    check("mr_enc_cnt", 32'(enc_word_cnt), 32'd0);
    check("mr_dec_cnt", 32'(dec_word_cnt), 32'd0);
    check("mr_in_ready", 32'(enc_in_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("mr_post_in_ready", 32'(enc_in_ready), 32'd0);
    check("mr_post_keyed", 32'(enc_keyed), 32'd0);
    check("mr_post_out_valid", 32'(enc_out_valid), 32'd0);
    in_valid = 1'b0;
    dec_out_ready = 1'b1;
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
